mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package mem_bus_pkg;

  // Transaction FSM: arbitrate in IDLE, drive the RAM in ACCESS, ack in RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Read-latency counter width; RD_LAT is 1..4, so the counter spans 0..3.
  localparam int LAT_W = 2;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority, then lock override,
// then round-robin starting just above the last granted index.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int IW        = idx_w(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IW-1:0]        rr_ptr,
  input  logic                 prio_en,
  input  logic [IW-1:0]        prio_idx,
  input  logic                 lock_en,
  input  logic [IW-1:0]        lock_idx,
  output logic [N_MASTERS-1:0] gnt,
  output logic [IW-1:0]        gnt_idx,
  output logic                 gnt_valid,
  output logic                 lock_hit
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Pick one requester in priority order and expand it to one-hot.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    lock_hit  = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (prio_en && req[prio_idx]) begin
      gnt_idx   = prio_idx;
      gnt_valid = 1'b1;
    end else if (lock_en && req[lock_idx]) begin
      gnt_idx   = lock_idx;
      gnt_valid = 1'b1;
      lock_hit  = 1'b1;
    end else begin
      for (int k = 1; k <= N_MASTERS; k++) begin
        cand     = (int'(rr_ptr) + k) % N_MASTERS;
        cand_idx = IW'(cand);
        if (!gnt_valid && req[cand_idx]) begin
          gnt_idx   = cand_idx;
          gnt_valid = 1'b1;
        end
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master arbiter onto one RAM port with registered, fully handshaken
// transactions, round-robin fairness, one optional priority master and
// bounded locked bursts.
//
// Handshake: a master raises m_req with m_we/m_addr/m_wdata stable and holds
// it until its one-cycle m_ack pulse. The request fields are captured only on
// the edge that leaves IDLE; after that the transaction completes and acks
// regardless of what the master does. A request still high during the ack
// cycle is treated as a fresh request in the following IDLE cycle.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int RD_LAT      = 1,
  parameter int PRIO_MASTER = 1,
  parameter int MAX_BURST   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS-1:0]          m_lock,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic                          ram_oe,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata
);

  localparam int            IW       = idx_w(N_MASTERS);
  localparam int            BW       = idx_w(MAX_BURST + 1);
  localparam bit            PRIO_EN  = (PRIO_MASTER < N_MASTERS);
  localparam logic [IW-1:0] PRIO_IDX = PRIO_EN ? IW'(PRIO_MASTER) : '0;

  state_t                state;
  logic [IW-1:0]         grant_idx;
  logic [N_MASTERS-1:0]  grant_oh;
  logic [IW-1:0]         rr_ptr;
  logic                  lock_valid;
  logic [BW-1:0]         burst_cnt;
  logic [LAT_W-1:0]      lat_cnt;

  logic [N_MASTERS-1:0]  arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  arb_valid;
  logic                  arb_lock_hit;
  logic                  lock_en;

  logic [ADDR_W-1:0]     addr_arr  [N_MASTERS];
  logic [DATA_W-1:0]     wdata_arr [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = m_wdata[i*DATA_W +: DATA_W];
  end

  // The lock is honoured only while the burst budget is not exhausted; the
  // locked master is always the one granted last.
  assign lock_en = lock_valid && (burst_cnt < BW'(MAX_BURST));

  rr_arbiter #(
    .N_MASTERS (N_MASTERS),
    .IW        (IW)
  ) u_rr_arbiter (
    .req       (m_req),
    .rr_ptr    (rr_ptr),
    .prio_en   (PRIO_EN),
    .prio_idx  (PRIO_IDX),
    .lock_en   (lock_en),
    .lock_idx  (grant_idx),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid),
    .lock_hit  (arb_lock_hit)
  );

  // Transaction FSM with registered RAM controls, ack, read data and
  // arbitration bookkeeping (pointer, lock, burst count).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_idx  <= '0;
      grant_oh   <= '0;
      rr_ptr     <= IW'(N_MASTERS - 1);
      lock_valid <= 1'b0;
      burst_cnt  <= '0;
      lat_cnt    <= '0;
      m_ack      <= '0;
      m_rdata    <= '0;
      ram_cs     <= 1'b0;
      ram_we     <= 1'b0;
      ram_oe     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      m_ack <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_idx <= arb_idx;
            grant_oh  <= arb_gnt;
            rr_ptr    <= arb_idx;
            ram_cs    <= 1'b1;
            ram_we    <= m_we[arb_idx];
            ram_oe    <= !m_we[arb_idx];
            ram_addr  <= addr_arr[arb_idx];
            ram_wdata <= wdata_arr[arb_idx];
            lat_cnt   <= '0;
            burst_cnt <= arb_lock_hit ? burst_cnt + BW'(1) : '0;
            if (arb_idx != grant_idx) lock_valid <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (ram_we || (lat_cnt == LAT_W'(RD_LAT - 1))) begin
            if (!ram_we) m_rdata <= ram_rdata;
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            ram_oe <= 1'b0;
            m_ack  <= grant_oh;
            state  <= RESP;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        RESP: begin
          lock_valid <= m_lock[grant_idx];
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter using two configurations:
//   u_a: 2 masters, RD_LAT=1, PRIO_MASTER=1, backed by a small RAM model.
//   u_b: 3 masters, RD_LAT=3, priority disabled, MAX_BURST=4, ram_rdata
//        driven cycle by cycle from the bench.
module tb_mem_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  int n_cmp = 0;
  int n_err = 0;

  // Clock and resets
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;

  // Instance A signals
  logic [1:0]      a_req, a_we, a_lock, a_ack;
  logic [2*AW-1:0] a_addr;
  logic [2*DW-1:0] a_wdata;
  logic [DW-1:0]   a_rdata, a_rwdata, a_rrdata;
  logic [AW-1:0]   a_raddr;
  logic            a_cs, a_rwe, a_oe;

  // Instance B signals
  logic [2:0]      b_req, b_we, b_lock, b_ack;
  logic [3*AW-1:0] b_addr;
  logic [3*DW-1:0] b_wdata;
  logic [DW-1:0]   b_rdata, b_rwdata, b_rrdata;
  logic [AW-1:0]   b_raddr;
  logic            b_cs, b_rwe, b_oe;

  mem_bus_arbiter #(
    .N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1),
    .PRIO_MASTER(1), .MAX_BURST(8)
  ) u_a (
    .clk(clk), .reset(rst_a),
    .m_req(a_req), .m_we(a_we), .m_lock(a_lock),
    .m_addr(a_addr), .m_wdata(a_wdata),
    .m_ack(a_ack), .m_rdata(a_rdata),
    .ram_cs(a_cs), .ram_we(a_rwe), .ram_oe(a_oe),
    .ram_addr(a_raddr), .ram_wdata(a_rwdata), .ram_rdata(a_rrdata)
  );

  mem_bus_arbiter #(
    .N_MASTERS(3), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3),
    .PRIO_MASTER(3), .MAX_BURST(4)
  ) u_b (
    .clk(clk), .reset(rst_b),
    .m_req(b_req), .m_we(b_we), .m_lock(b_lock),
    .m_addr(b_addr), .m_wdata(b_wdata),
    .m_ack(b_ack), .m_rdata(b_rdata),
    .ram_cs(b_cs), .ram_we(b_rwe), .ram_oe(b_oe),
    .ram_addr(b_raddr), .ram_wdata(b_rwdata), .ram_rdata(b_rrdata)
  );

  // Small RAM behind instance A: write on the clock, combinational read.
  logic [DW-1:0] mem_a [256];
  always @(posedge clk) begin
    if (a_cs && a_rwe) mem_a[a_raddr[7:0]] <= a_rwdata;
  end
  assign a_rrdata = (a_cs && a_oe) ? mem_a[a_raddr[7:0]] : '0;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_a(input int m, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    a_we[m]              = we;
    a_addr[m*AW +: AW]   = addr;
    a_wdata[m*DW +: DW]  = data;
  endtask

  task automatic put_b(input int m, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    b_we[m]              = we;
    b_addr[m*AW +: AW]   = addr;
    b_wdata[m*DW +: DW]  = data;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  int          exp_g [6];
  logic [2:0]  exp_oh;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_req = '0; a_we = '0; a_lock = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_lock = '0; b_addr = '0; b_wdata = '0;
    b_rrdata = '0;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset values
    check("rst_ack",   a_ack, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_ctl",   {a_cs, a_rwe, a_oe}, 0);
    check("rst_addr",  a_raddr, 0);
    check("rst_wdata", a_rwdata, 0);
    check("rst_b_out", {b_cs, b_rwe, b_oe, b_ack}, 0);
    tick();

    // Master 0 write 0x10 <- 0xDEAD
    put_a(0, 1'b1, 16'h0010, 16'hDEAD); a_req = 2'b01;
    tick();
    check("wr_c1_ctl",   {a_cs, a_rwe, a_oe}, 3'b110);
    check("wr_c1_addr",  a_raddr, 16'h0010);
    check("wr_c1_wdata", a_rwdata, 16'hDEAD);
    check("wr_c1_ack",   a_ack, 0);
    tick();
    check("wr_c2_ack",   a_ack, 2'b01);
    check("wr_c2_ctl",   {a_cs, a_rwe, a_oe}, 0);
    a_req = 2'b00;
    tick();
    check("wr_ack_pulse", a_ack, 0);

    // Read back 0x10
    put_a(0, 1'b0, 16'h0010, 16'h0000); a_req = 2'b01;
    tick();
    check("rd_c1_ctl", {a_cs, a_rwe, a_oe}, 3'b101);
    tick();
    check("rd_c2_ack",   a_ack, 2'b01);
    check("rd_c2_rdata", a_rdata, 16'hDEAD);
    a_req = 2'b00;
    tick();

    // A write leaves m_rdata untouched
    put_a(0, 1'b1, 16'h0020, 16'hBEEF); a_req = 2'b01;
    tick(); tick();
    check("wr2_ack",   a_ack, 2'b01);
    check("rdata_hold", a_rdata, 16'hDEAD);
    a_req = 2'b00;
    tick();
    check("ram_written", mem_a[8'h20], 16'hBEEF);

    // Priority: master 0 in flight is not preempted; master 1 then beats
    // master 0's held request.
    put_a(0, 1'b1, 16'h0030, 16'h1111); a_req = 2'b01;
    tick();
    check("prio_first_addr", a_raddr, 16'h0030);
    put_a(1, 1'b1, 16'h0031, 16'h2222); a_req = 2'b11;
    tick();
    check("prio_first_ack", a_ack, 2'b01);
    tick();
    check("prio_idle_cs", a_cs, 0);
    tick();
    check("prio_win_addr", a_raddr, 16'h0031);
    tick();
    check("prio_win_ack", a_ack, 2'b10);
    a_req = 2'b01;
    tick(); tick();
    check("prio_next_addr", a_raddr, 16'h0030);
    tick();
    check("prio_next_ack", a_ack, 2'b01);
    a_req = 2'b00;
    tick();

    // Round-robin: three continuous writers, grants 0,1,2,0,1,2
    for (int i = 0; i < 3; i++) put_b(i, 1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    b_req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      exp_oh = 3'b001 << (g % 3);
      tick();
      check("rr_addr", b_raddr, 16'h0100 + 16'(g % 3));
      tick();
      check("rr_ack", b_ack, exp_oh);
      tick();
    end
    b_req = 3'b000;
    tick();

    // Locked burst: master 0 gets 1 + 4 re-grants, then master 1
    put_b(0, 1'b1, 16'h0200, 16'hB000);
    put_b(1, 1'b1, 16'h0201, 16'hB001);
    b_lock = 3'b001; b_req = 3'b011;
    exp_g = '{0, 0, 0, 0, 0, 1};
    for (int g = 0; g < 6; g++) begin
      exp_oh = 3'b001 << exp_g[g];
      tick();
      check("burst_addr", b_raddr, 16'h0200 + 16'(exp_g[g]));
      tick();
      check("burst_ack", b_ack, exp_oh);
      tick();
    end
    b_req = 3'b000; b_lock = 3'b000;
    tick();

    // Reset in the ACCESS cycle of a write
    put_b(1, 1'b1, 16'h0250, 16'h7777); b_req = 3'b010;
    tick();
    check("abort_cs", b_cs, 1);
    rst_b = 1'b1; b_req = 3'b000;
    tick();
    check("abort_ctl",   {b_cs, b_rwe, b_oe}, 0);
    check("abort_ack",   b_ack, 0);
    check("abort_addr",  b_raddr, 0);
    check("abort_wdata", b_rwdata, 0);
    rst_b = 1'b0;
    tick();
    check("abort_no_ack", b_ack, 0);
    for (int i = 0; i < 3; i++) put_b(i, 1'b1, 16'h0260 + 16'(i), 16'hC000 + 16'(i));
    b_req = 3'b111;
    tick();
    check("post_rst_winner", b_raddr, 16'h0260);
    tick();
    check("post_rst_ack", b_ack, 3'b001);
    b_req = 3'b000;
    tick();

    // RD_LAT=3 read by master 2
    put_b(2, 1'b0, 16'h0300, 16'h0000); b_req = 3'b100;
    tick();
    check("lat_c1_ctl", {b_cs, b_rwe, b_oe}, 3'b101);
    b_rrdata = 16'h00A1;
    tick();
    check("lat_c2_ctl", {b_cs, b_rwe, b_oe}, 3'b101);
    check("lat_c2_ack", b_ack, 0);
    b_rrdata = 16'h00A2;
    tick();
    check("lat_c3_ctl", {b_cs, b_rwe, b_oe}, 3'b101);
    b_rrdata = 16'h00A3;
    tick();
    check("lat_c4_ack",   b_ack, 3'b100);
    check("lat_c4_rdata", b_rdata, 16'h00A3);
    check("lat_c4_ctl",   {b_cs, b_rwe, b_oe}, 0);
    b_req = 3'b000; b_rrdata = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
